id_hazard_scoreboard: RTL

- Parametrised successor to the decode-stage hazard logic.
- Replaces the fixed five-stage WriteRegister/RegWrite comparison chain with a per-register countdown scoreboard.
- Handles any pipeline depth, any number of source operands and variable per-instruction write latency (ALU, MEM, SAD-chain ops).
- Sits in ID beside the register file and drives the ID stall and issue-accept signals.

---
 rtl/id_hazard_scoreboard_if.sv | 32 +++
 rtl/id_hazard_scoreboard.sv | 90 +++++++++
 2 files changed

// File: rtl/id_hazard_scoreboard_if.sv
// Issue-side bundle between the ID stage and the hazard scoreboard.
// master = ID issue logic, slave = scoreboard.
interface id_hazard_scoreboard_if #(
    parameter int ADDR_W  = 5,
    parameter int LAT_W   = 3,
    parameter int NUM_SRC = 2
);
    logic                      issue_valid;
    logic                      flush;
    logic                      issue_we;
    logic [ADDR_W-1:0]         issue_dst;
    logic [LAT_W-1:0]          issue_lat;
    logic [NUM_SRC-1:0]        src_used;
    logic [NUM_SRC*ADDR_W-1:0] src_addr;
    logic                      stall;
    logic                      issue_accept;
    logic [NUM_SRC-1:0]        src_busy;
    logic [NUM_SRC-1:0]        src_bypass;
    logic                      pending_any;

    modport master (
        output issue_valid, flush, issue_we, issue_dst, issue_lat,
        output src_used, src_addr,
        input  stall, issue_accept, src_busy, src_bypass, pending_any
    );

    modport slave (
        input  issue_valid, flush, issue_we, issue_dst, issue_lat,
        input  src_used, src_addr,
        output stall, issue_accept, src_busy, src_bypass, pending_any
    );
endinterface

// File: rtl/id_hazard_scoreboard.sv
// ID-stage per-register countdown scoreboard driving stall/issue-accept.
// Optional macro SCOREBOARD_FWD_EN: treat cnt==1 as satisfied by the WB bypass.
module id_hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int LAT_W    = 3,
    parameter int NUM_SRC  = 2
) (
    input logic Clk,
    input logic Rst,
    id_hazard_scoreboard_if.slave bus
);
    localparam logic [LAT_W-1:0] ONE = LAT_W'(1);

    logic [LAT_W-1:0]   cnt     [1:NUM_REGS-1];
    logic [LAT_W-1:0]   cnt_nxt [1:NUM_REGS-1];
    logic [LAT_W-1:0]   src_cnt [NUM_SRC];
    logic [NUM_SRC-1:0] busy;
    logic [NUM_SRC-1:0] bypass;
    logic               live;
    logic               stall;
    logic               accept;
    logic               pend;

    function automatic logic [LAT_W-1:0] dec_of(input logic [LAT_W-1:0] c);
        return (c == '0) ? '0 : c - ONE;
    endfunction

    // Register 0 and out-of-range addresses fall through with a zero count.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_cnt[i] = '0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (bus.src_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(r))
                    src_cnt[i] = cnt[r];
            end
        end
    end

    always_comb begin
        busy   = '0;
        bypass = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
`ifdef SCOREBOARD_FWD_EN
            busy[i]   = bus.src_used[i] & (src_cnt[i] > ONE);
            bypass[i] = bus.src_used[i] & (src_cnt[i] == ONE);
`else
            busy[i]   = bus.src_used[i] & (src_cnt[i] != '0);
`endif
        end
    end

    assign live   = bus.issue_valid & ~bus.flush;
    assign stall  = live & (|busy);
    assign accept = live & ~stall;

    always_comb begin
        pend = 1'b0;
        for (int r = 1; r < NUM_REGS; r++)
            pend = pend | (cnt[r] != '0);
    end

    // A new write never shortens an outstanding one (WAW keeps the max).
    always_comb begin
        for (int r = 1; r < NUM_REGS; r++) begin
            cnt_nxt[r] = dec_of(cnt[r]);
            if (accept && bus.issue_we && bus.issue_lat != '0 &&
                bus.issue_dst == ADDR_W'(r)) begin
                if (bus.issue_lat > dec_of(cnt[r]))
                    cnt_nxt[r] = bus.issue_lat;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int r = 1; r < NUM_REGS; r++)
                cnt[r] <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++)
                cnt[r] <= cnt_nxt[r];
        end
    end

    assign bus.stall        = stall;
    assign bus.issue_accept = accept;
    assign bus.src_busy     = busy;
    assign bus.src_bypass   = bypass;
    assign bus.pending_any  = pend;
endmodule
